// File: rtl/vec_sub_pkg.sv
// Shared constants and types for the fp16 vector-subtract path.
// Vectors are three packed fp16 lanes {x, y, z}, with x in the top bits.
package vec_sub_pkg;

    localparam int FP16_W          = 16;
    localparam int VEC_W           = 3 * FP16_W;
    localparam int DEFAULT_LATENCY = 10;

    typedef struct packed {
        logic [FP16_W-1:0] x;
        logic [FP16_W-1:0] y;
        logic [FP16_W-1:0] z;
    } vec3_fp16_t;

endpackage

// File: rtl/vec_sub_arbiter_rr_arbiter.sv
// Round-robin picker: scans from rr_ptr upward (wrapping) and grants the first active request.
// Produces a one-hot grant plus the winning index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    // first requester at or after rr_ptr, modulo NUM_REQ
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_valid && req[j]) begin
                gnt[j]    = 1'b1;
                gnt_idx   = IDX_W'(j);
                gnt_valid = 1'b1;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/vec_sub_arbiter.sv
// Shares one pipelined fp16 vector-subtract datapath among NUM_REQ requesters.
// A {valid, idx} delay line matched to the datapath latency steers each result to its owner.
module vec_sub_arbiter
    import vec_sub_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int VEC_W   = vec_sub_pkg::VEC_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*VEC_W-1:0]       vec_a_in,
    input  logic [NUM_REQ*VEC_W-1:0]       vec_b_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           dp_en,
    output logic [VEC_W-1:0]               dp_a,
    output logic [VEC_W-1:0]               dp_b,
    input  logic [VEC_W-1:0]               dp_q,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [VEC_W-1:0]               rsp_q,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY+1);

    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] rr_ptr_next_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_valid_s;
    logic [IDX_W-1:0] issue_idx_r;
    logic             dp_en_r;
    logic [VEC_W-1:0] dp_a_r;
    logic [VEC_W-1:0] dp_b_r;
    logic [LATENCY-1:0] tag_valid_r;
    logic [IDX_W-1:0]   tag_idx_r [LATENCY];
    logic               ret_s;
    logic [CNT_W-1:0]   in_flight_r;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_r),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // pointer advances past the winner; holds when nothing is granted
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (gnt_valid_s) begin
            if (gnt_idx_s == IDX_W'(NUM_REQ-1)) begin
                rr_ptr_next_s = '0;
            end else begin
                rr_ptr_next_s = gnt_idx_s + IDX_W'(1);
            end
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end
    end

    // issue stage: capture the winner's operands one cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            dp_en_r     <= 1'b0;
            dp_a_r      <= '0;
            dp_b_r      <= '0;
            issue_idx_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
            dp_en_r  <= gnt_valid_s;
            if (gnt_valid_s) begin
                dp_a_r      <= vec_a_in[int'(gnt_idx_s)*VEC_W +: VEC_W];
                dp_b_r      <= vec_b_in[int'(gnt_idx_s)*VEC_W +: VEC_W];
                issue_idx_r <= gnt_idx_s;
            end else begin
                dp_a_r      <= dp_a_r;
                dp_b_r      <= dp_b_r;
                issue_idx_r <= issue_idx_r;
            end
        end
    end

    // owner tags travel alongside the datapath so they surface together with dp_q
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_idx_r[s] <= '0;
            end
        end else begin
            tag_valid_r[0] <= dp_en_r;
            tag_idx_r[0]   <= issue_idx_r;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_r[s] <= tag_valid_r[s-1];
                tag_idx_r[s]   <= tag_idx_r[s-1];
            end
        end
    end

    assign ret_s = tag_valid_r[LATENCY-1];

    // outstanding-op counter; simultaneous issue and return cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_r <= '0;
        end else begin
            case ({dp_en_r, ret_s})
                2'b10:   in_flight_r <= in_flight_r + CNT_W'(1);
                2'b01:   in_flight_r <= in_flight_r - CNT_W'(1);
                default: in_flight_r <= in_flight_r;
            endcase
        end
    end

    // steer the returning result to its owner
    always_comb begin
        rsp_valid = '0;
        if (ret_s) begin
            rsp_valid[tag_idx_r[LATENCY-1]] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign rsp_q     = dp_q;
    assign dp_en     = dp_en_r;
    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign in_flight = in_flight_r;
    assign busy      = (in_flight_r != '0) | dp_en_r;

endmodule

// File: tb/tb_vec_sub_arbiter.sv
// Directed bench for vec_sub_arbiter: a behavioural fp16 datapath delays results by LATENCY,
// a monitor logs every response, and each test checks grants, issue timing and returns.
module tb_vec_sub_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 10;
    localparam int VEC_W   = 48;
    localparam int CNT_W   = $clog2(LATENCY+1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req = '0;
    logic [VEC_W-1:0]         a_vec [NUM_REQ];
    logic [VEC_W-1:0]         b_vec [NUM_REQ];
    logic [NUM_REQ*VEC_W-1:0] vec_a_in;
    logic [NUM_REQ*VEC_W-1:0] vec_b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic                     dp_en;
    logic [VEC_W-1:0]         dp_a;
    logic [VEC_W-1:0]         dp_b;
    logic [VEC_W-1:0]         dp_q;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [VEC_W-1:0]         rsp_q;
    logic [CNT_W-1:0]         in_flight;
    logic                     busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int peak  = 0;
    int onehot_err = 0;

    int               log_cyc [$];
    logic [NUM_REQ-1:0] log_vld [$];
    logic [VEC_W-1:0]   log_q   [$];

    logic [VEC_W-1:0] pipe [LATENCY];

    assign vec_a_in = {a_vec[3], a_vec[2], a_vec[1], a_vec[0]};
    assign vec_b_in = {b_vec[3], b_vec[2], b_vec[1], b_vec[0]};
    assign dp_q     = pipe[LATENCY-1];

    vec_sub_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .req(req), .vec_a_in(vec_a_in), .vec_b_in(vec_b_in),
        .gnt(gnt), .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_q(dp_q),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .in_flight(in_flight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Subtraction for the handful of fp16 operand pairs this bench uses.
    function automatic logic [15:0] lane_sub(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h0000)                       return a;
        else if (a == b)                         return 16'h0000;
        else if (a == 16'h3C00 && b == 16'h3800) return 16'h3800;
        else if (a == 16'h4000 && b == 16'h3C00) return 16'h3C00;
        else                                     return 16'hFFFF;
    endfunction

    function automatic logic [47:0] vec_sub(input logic [47:0] a, input logic [47:0] b);
        return {lane_sub(a[47:32], b[47:32]), lane_sub(a[31:16], b[31:16]), lane_sub(a[15:0], b[15:0])};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= vec_sub(dp_a, dp_b);
        for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
    end

    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            log_cyc.push_back(cyc);
            log_vld.push_back(rsp_valid);
            log_q.push_back(rsp_q);
        end
        if ($countones(rsp_valid) > 1 || $countones(gnt) > 1) onehot_err++;
        if (int'(in_flight) > peak) peak = int'(in_flight);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_vld.delete();
        log_q.delete();
    endtask

    // one op by a single requester, drained and logged away
    task automatic single_grant(input logic [NUM_REQ-1:0] r);
        req = r;
        next_cycle();
        req = '0;
        wait_until(cyc + 13);
        clear_log();
    endtask

    initial begin
        int t;
        int viol;
        logic [VEC_W-1:0] snap;
        for (int s = 0; s < LATENCY; s++) pipe[s] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_vec[i] = {16'h4100 + 16'(i), 16'h4200 + 16'(i), 16'h4300 + 16'(i)};
            b_vec[i] = 48'h0;
        end

        // reset state
        next_cycle();
        next_cycle();
        check_eq("rst_dp_en", 64'(dp_en), 64'h0);
        check_eq("rst_in_flight", 64'(in_flight), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_dp_a", 64'(dp_a), 64'h0);
        check_eq("rst_gnt", 64'(gnt), 64'h0);
        rst = 1'b0;
        next_cycle();

        // single op from requester 2
        clear_log();
        a_vec[2] = {16'h3C00, 16'h4000, 16'h3C00};
        b_vec[2] = {16'h3800, 16'h3C00, 16'h3C00};
        req = 4'b0100;
        t = cyc;
        #1;
        check_eq("t1_gnt", 64'(gnt), 64'h4);
        next_cycle();
        req = '0;
        check_eq("t1_dp_en", 64'(dp_en), 64'h1);
        check_eq("t1_dp_a", 64'(dp_a), 64'h3C00_4000_3C00);
        check_eq("t1_dp_b", 64'(dp_b), 64'h3800_3C00_3C00);
        wait_until(t + 14);
        check_eq("t1_nrsp", 64'(log_cyc.size()), 64'h1);
        if (log_cyc.size() >= 1) begin
            check_eq("t1_rsp_cyc", 64'(log_cyc[0]), 64'(t + 11));
            check_eq("t1_rsp_vld", 64'(log_vld[0]), 64'h4);
            check_eq("t1_rsp_q", 64'(log_q[0]), 64'h3800_3C00_0000);
        end
        a_vec[2] = {16'h4102, 16'h4202, 16'h4302};
        b_vec[2] = 48'h0;

        // contention: rr_ptr is 3; one grant to requester 3 wraps it to 0
        single_grant(4'b1000);
        req = 4'b1111;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t2_gnt", 64'(gnt), 64'(1 << k));
            next_cycle();
        end
        req = '0;
        wait_until(t + 17);
        check_eq("t2_nrsp", 64'(log_cyc.size()), 64'h4);
        if (log_cyc.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check_eq("t2_rsp_cyc", 64'(log_cyc[k]), 64'(t + 11 + k));
                check_eq("t2_rsp_vld", 64'(log_vld[k]), 64'(1 << k));
                check_eq("t2_rsp_q", 64'(log_q[k]), 64'(a_vec[k]));
            end
        end
        clear_log();

        // fairness: grant requester 1 so rr_ptr becomes 2, then alternate 2 and 0
        single_grant(4'b0010);
        req = 4'b0101;
        #1;
        check_eq("t3_gnt0", 64'(gnt), 64'h4);
        next_cycle();
        check_eq("t3_gnt1", 64'(gnt), 64'h1);
        next_cycle();
        check_eq("t3_gnt2", 64'(gnt), 64'h4);
        next_cycle();
        req = '0;
        wait_until(cyc + 13);
        check_eq("t3_nrsp", 64'(log_cyc.size()), 64'h3);
        clear_log();

        // back-to-back from requester 0 alone
        peak = 0;
        req = 4'b0001;
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t4_gnt", 64'(gnt), 64'h1);
            next_cycle();
        end
        req = '0;
        wait_until(t + 18);
        check_eq("t4_nrsp", 64'(log_cyc.size()), 64'h5);
        if (log_cyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check_eq("t4_rsp_cyc", 64'(log_cyc[k]), 64'(t + 11 + k));
                check_eq("t4_rsp_vld", 64'(log_vld[k]), 64'h1);
            end
        end
        check_eq("t4_peak", 64'(peak), 64'h5);
        check_eq("t4_in_flight_end", 64'(in_flight), 64'h0);
        check_eq("t4_busy_end", 64'(busy), 64'h0);
        clear_log();

        // reset with three ops outstanding
        req = 4'b0001;
        t = cyc;
        next_cycle();
        next_cycle();
        next_cycle();
        req = '0;
        next_cycle();
        check_eq("t5_in_flight_pre", 64'(in_flight), 64'h3);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_eq("t5_in_flight_post", 64'(in_flight), 64'h0);
        check_eq("t5_dp_en_post", 64'(dp_en), 64'h0);
        check_eq("t5_busy_post", 64'(busy), 64'h0);
        wait_until(t + 21);
        check_eq("t5_no_rsp", 64'(log_cyc.size()), 64'h0);
        clear_log();
        req = 4'b0010;
        t = cyc;
        #1;
        check_eq("t5_gnt_after", 64'(gnt), 64'h2);
        next_cycle();
        req = '0;
        wait_until(t + 14);
        check_eq("t5_nrsp_after", 64'(log_cyc.size()), 64'h1);
        if (log_cyc.size() >= 1) begin
            check_eq("t5_rsp_cyc", 64'(log_cyc[0]), 64'(t + 11));
            check_eq("t5_rsp_vld", 64'(log_vld[0]), 64'h2);
            check_eq("t5_rsp_q", 64'(log_q[0]), 64'(a_vec[1]));
        end
        clear_log();

        // idle: nothing moves and rr_ptr (now 2) is kept
        snap = dp_a;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            if (gnt != '0 || dp_en || rsp_valid != '0 || dp_a != snap) viol++;
            next_cycle();
        end
        check_eq("t6_idle_viol", 64'(viol), 64'h0);
        req = 4'b1111;
        #1;
        check_eq("t6_gnt_ptr", 64'(gnt), 64'h4);
        next_cycle();
        req = '0;
        wait_until(cyc + 13);

        check_eq("onehot", 64'(onehot_err), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
